x_delay_line_ctrl: RTL and testbench
====================================

Name: x_delay_line_ctrl

Overview:
Controller at the far end of a chain of N_CELLS x_delay_line_cell instances.
- Launches a rising edge into the head of the chain and pulses the chain's capture enable once the cell synchronisers have settled.
- Clocks the captured snapshot out through the cells' serial shift path and decodes it into a propagation depth.
- Presents the result on a valid/ready interface.
- Returns the line to zero and lets it recover before the next measurement.

Parameters:
N_CELLS, 64, number of cells in the chain; shift cycles per measurement.
CAPTURE_DLY, 2, clock edges from o_dl rise to o_dl_en assertion; 2 matches the two-flop synchroniser in each cell; minimum 1.
RECOVER_CYCLES, 16, cycles o_dl is held low after result acceptance before IDLE; minimum 1.
W_COUNT, $clog2(N_CELLS+1), width of the popcount result.

Ports:
i_clk  in  1  clock
i_nrst  in  1  asynchronous active-low reset
i_start  in  1  request measurement; sampled only in IDLE
o_busy  out  1  high in every state except IDLE
o_dl  out  1  launch signal to cell 0 i_dl
o_dl_en  out  1  capture enable to all cells' i_dl_en
o_shift_en  out  1  shift enable to all cells' i_shift_en
i_shift  in  1  o_shift of the last cell (N_CELLS-1); cell 0 i_shift is tied 0 externally
o_result_valid  out  1  result available
i_result_ready  in  1  consumer accepts result
o_result_bits  out  N_CELLS  snapshot, bit k = cell k
o_result_count  out  W_COUNT  number of ones in snapshot
o_result_err  out  1  snapshot is not a thermometer code

Behaviour:
- Reset: i_nrst asynchronous, active-low; clock i_clk. All outputs 0, state IDLE, counters 0. Reset mid-operation aborts immediately: o_dl, o_dl_en, o_shift_en drop to 0 and any pending result is discarded.
- All outputs are registered.
- States: IDLE, WAIT, CAPTURE, SHIFT, DONE, RECOVER.
- IDLE: on an edge E0 with i_start=1, o_dl<=1, go to WAIT. i_start is ignored in all other states.
- WAIT: count edges. o_dl_en<=1 at edge E0+CAPTURE_DLY, then go to CAPTURE.
- CAPTURE: lasts exactly one cycle. On the next edge, o_dl_en<=0, o_shift_en<=1, o_dl<=0, shift counter cleared, go to SHIFT. o_dl_en and o_shift_en are never high together.
- SHIFT: o_shift_en stays high for exactly N_CELLS cycles.
  - i_shift is sampled on each of the N_CELLS edges while o_shift_en=1.
  - The j-th sample (j=0 first) is stored to o_result_bits[N_CELLS-1-j], because the first sample is the last cell's value before any shift.
  - On the N_CELLS-th sampling edge, o_shift_en<=0 and go to DONE.
- DONE: result fields updated on the edge entering DONE; o_result_valid=1 from that edge on.
  - o_result_count = popcount(bits).
  - o_result_err = 1 unless bits == (1<<count)-1, i.e. ones contiguous from cell 0. All-zero and all-ones are both legal.
  - Result fields are stable while valid=1.
  - On an edge with valid & ready: valid<=0, go to RECOVER.
- RECOVER: o_dl=0 for RECOVER_CYCLES edges, then IDLE. o_busy drops on the edge entering IDLE.
- Minimum measurement period with ready tied high: 1 + CAPTURE_DLY + N_CELLS + 1 + RECOVER_CYCLES cycles. i_start held high gives back-to-back measurements at this period.
- Counters are sized for N_CELLS and RECOVER_CYCLES with no wrap inside a state.

Test Plan:
1. Reset with N_CELLS=8, CAPTURE_DLY=2, RECOVER_CYCLES=4, then idle -> all outputs 0, o_busy=0; i_start pulse during reset has no effect.
2. i_start=1 at edge E0 -> o_dl rises E0; o_dl_en high E2–E3 only; o_shift_en high E3–E11; o_dl falls E3; o_result_valid rises E11.
3. Bench cell model holds snapshot cells0..7 = 1,1,1,0,0,0,0,0, so i_shift sequence = 0,0,0,0,0,1,1,1 -> o_result_bits=8'b0000_0111, o_result_count=3, o_result_err=0. All-ones -> count=8, err=0; all-zeros -> count=0, err=0.
4. Snapshot cells = 1,0,1,1,0,0,0,0 -> bits=8'b0000_1101, count=3, err=1.
5. i_result_ready low for 5 cycles after valid, i_start pulsed meanwhile -> valid and fields held constant, no new o_dl pulse. Ready high -> valid falls next edge, o_busy falls 4 edges later, and a start only then launches.
6. Assert i_nrst low at the 4th shift cycle -> o_shift_en, o_dl, o_busy go 0 asynchronously, no o_result_valid. After release, a fresh measurement completes correctly.

Source files
------------

// File: rtl/x_delay_line_ctrl.sv
// Delay-line measurement controller: launch, capture, serial readout, decode, recover.
// Result held on a valid/ready port; the line stays parked in DONE until the consumer accepts.
module x_delay_line_ctrl #(
   parameter int N_CELLS        = 64,
   parameter int CAPTURE_DLY    = 2,
   parameter int RECOVER_CYCLES = 16,
   parameter int W_COUNT        = $clog2(N_CELLS + 1)
) (
   input  logic               i_clk,
   input  logic               i_nrst,
   input  logic               i_start,
   output logic               o_busy,
   output logic               o_dl,
   output logic               o_dl_en,
   output logic               o_shift_en,
   input  logic               i_shift,
   output logic               o_result_valid,
   input  logic               i_result_ready,
   output logic [N_CELLS-1:0] o_result_bits,
   output logic [W_COUNT-1:0] o_result_count,
   output logic               o_result_err
);

   localparam int MAX_DR  = (CAPTURE_DLY > RECOVER_CYCLES) ? CAPTURE_DLY : RECOVER_CYCLES;
   localparam int CNT_MAX = (MAX_DR > N_CELLS) ? MAX_DR : N_CELLS;
   localparam int W_CNT   = $clog2(CNT_MAX + 1);

   localparam logic [W_CNT-1:0] CNT_CAP   = W_CNT'(CAPTURE_DLY);
   localparam logic [W_CNT-1:0] CNT_SHIFT = W_CNT'(N_CELLS - 1);
   localparam logic [W_CNT-1:0] CNT_REC   = W_CNT'(RECOVER_CYCLES);
   localparam logic [W_CNT-1:0] CNT_ONE   = W_CNT'(1);

   localparam logic [2:0] S_IDLE    = 3'd0;
   localparam logic [2:0] S_WAIT    = 3'd1;
   localparam logic [2:0] S_CAPTURE = 3'd2;
   localparam logic [2:0] S_SHIFT   = 3'd3;
   localparam logic [2:0] S_DONE    = 3'd4;
   localparam logic [2:0] S_RECOVER = 3'd5;

   logic [2:0]         state_q,    state_d;
   logic [W_CNT-1:0]   cnt_q,      cnt_d;
   logic               busy_q,     busy_d;
   logic               dl_q,       dl_d;
   logic               dl_en_q,    dl_en_d;
   logic               shift_en_q, shift_en_d;
   logic [N_CELLS-1:0] sreg_q,     sreg_d;
   logic               valid_q,    valid_d;
   logic [N_CELLS-1:0] bits_q,     bits_d;
   logic [W_COUNT-1:0] count_q,    count_d;
   logic               err_q,      err_d;

   logic [N_CELLS-1:0] sreg_next;

   function automatic logic [W_COUNT-1:0] popcount(input logic [N_CELLS-1:0] v);
      logic [W_COUNT-1:0] c;
      c = '0;
      for (int k = 0; k < N_CELLS; k++) begin
         c = c + W_COUNT'(v[k]);
      end
      return c;
   endfunction

   // A thermometer code (ones contiguous from bit 0) has no bit in common with itself plus one.
   function automatic logic is_thermo(input logic [N_CELLS-1:0] v);
      logic [N_CELLS:0] ext;
      logic [N_CELLS:0] inc;
      ext = {1'b0, v};
      inc = ext + (N_CELLS + 1)'(1);
      return (ext & inc) == '0;
   endfunction

   // First sample is the last cell, so shifting in at bit 0 lands it at bit N_CELLS-1.
   assign sreg_next = (sreg_q << 1) | N_CELLS'(i_shift);

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      dl_d       = dl_q;
      dl_en_d    = dl_en_q;
      shift_en_d = shift_en_q;
      sreg_d     = sreg_q;
      valid_d    = valid_q;
      bits_d     = bits_q;
      count_d    = count_q;
      err_d      = err_q;

      case (state_q)
         S_IDLE: begin
            if (i_start) begin
               dl_d    = 1'b1;
               cnt_d   = CNT_ONE;
               state_d = S_WAIT;
            end
         end
         S_WAIT: begin
            if (cnt_q == CNT_CAP) begin
               dl_en_d = 1'b1;
               state_d = S_CAPTURE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_CAPTURE: begin
            dl_en_d    = 1'b0;
            shift_en_d = 1'b1;
            dl_d       = 1'b0;
            cnt_d      = '0;
            sreg_d     = '0;
            state_d    = S_SHIFT;
         end
         S_SHIFT: begin
            sreg_d = sreg_next;
            if (cnt_q == CNT_SHIFT) begin
               shift_en_d = 1'b0;
               valid_d    = 1'b1;
               bits_d     = sreg_next;
               count_d    = popcount(sreg_next);
               err_d      = ~is_thermo(sreg_next);
               state_d    = S_DONE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         S_DONE: begin
            if (i_result_ready) begin
               valid_d = 1'b0;
               cnt_d   = CNT_ONE;
               state_d = S_RECOVER;
            end
         end
         S_RECOVER: begin
            if (cnt_q == CNT_REC) begin
               cnt_d   = '0;
               state_d = S_IDLE;
            end else begin
               cnt_d = cnt_q + CNT_ONE;
            end
         end
         default: begin
            dl_d       = 1'b0;
            dl_en_d    = 1'b0;
            shift_en_d = 1'b0;
            valid_d    = 1'b0;
            cnt_d      = '0;
            state_d    = S_IDLE;
         end
      endcase

      busy_d = (state_d != S_IDLE);
   end

   always_ff @(posedge i_clk or negedge i_nrst) begin
      if (!i_nrst) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         busy_q     <= 1'b0;
         dl_q       <= 1'b0;
         dl_en_q    <= 1'b0;
         shift_en_q <= 1'b0;
         sreg_q     <= '0;
         valid_q    <= 1'b0;
         bits_q     <= '0;
         count_q    <= '0;
         err_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         busy_q     <= busy_d;
         dl_q       <= dl_d;
         dl_en_q    <= dl_en_d;
         shift_en_q <= shift_en_d;
         sreg_q     <= sreg_d;
         valid_q    <= valid_d;
         bits_q     <= bits_d;
         count_q    <= count_d;
         err_q      <= err_d;
      end
   end

   assign o_busy         = busy_q;
   assign o_dl           = dl_q;
   assign o_dl_en        = dl_en_q;
   assign o_shift_en     = shift_en_q;
   assign o_result_valid = valid_q;
   assign o_result_bits  = bits_q;
   assign o_result_count = count_q;
   assign o_result_err   = err_q;

endmodule

// File: tb/tb_x_delay_line_ctrl.sv
// Bench for x_delay_line_ctrl: a behavioural cell chain feeds i_shift, results checked
// against snapshot-derived expectations (popcount, thermometer legality, cycle timing).
module tb_x_delay_line_ctrl;

   localparam int N  = 8;
   localparam int CD = 2;
   localparam int R  = 4;
   localparam int WC = $clog2(N + 1);

   logic          clk = 1'b0;
   logic          nrst;
   logic          start;
   logic          ready;
   logic          shift_in;
   logic          o_busy, o_dl, o_dl_en, o_shift_en, o_result_valid, o_result_err;
   logic [N-1:0]  o_result_bits;
   logic [WC-1:0] o_result_count;

   int checks   = 0;
   int failures = 0;

   logic [N-1:0] snapshot = '0;
   logic [N-1:0] chain    = '0;

   always #5 clk = ~clk;

   x_delay_line_ctrl #(
      .N_CELLS(N), .CAPTURE_DLY(CD), .RECOVER_CYCLES(R), .W_COUNT(WC)
   ) u_dut (
      .i_clk(clk), .i_nrst(nrst), .i_start(start), .o_busy(o_busy),
      .o_dl(o_dl), .o_dl_en(o_dl_en), .o_shift_en(o_shift_en), .i_shift(shift_in),
      .o_result_valid(o_result_valid), .i_result_ready(ready),
      .o_result_bits(o_result_bits), .o_result_count(o_result_count),
      .o_result_err(o_result_err)
   );

   // Cell chain: capture loads the snapshot, shift moves cell k-1 into cell k, cell 0 takes 0.
   always @(posedge clk) begin
      if (o_dl_en)         chain <= snapshot;
      else if (o_shift_en) chain <= chain << 1;
   end
   assign shift_in = chain[N-1];

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   function automatic logic exp_err(input logic [N-1:0] s);
      int unsigned c;
      logic [N:0]  m;
      c = $countones(s);
      m = (N + 1)'((1 << c) - 1);
      return {1'b0, s} != m;
   endfunction

   task automatic check_idle(input string tag);
      check({tag, "_busy"},     o_busy,         0);
      check({tag, "_dl"},       o_dl,           0);
      check({tag, "_dl_en"},    o_dl_en,        0);
      check({tag, "_shift_en"}, o_shift_en,     0);
      check({tag, "_valid"},    o_result_valid, 0);
   endtask

   task automatic measure(input logic [N-1:0] snap, input int rdy_dly);
      snapshot = snap;
      start = 1'b1;
      tick();
      start = 1'b0;
      check("launch_dl",    o_dl,    1);
      check("launch_busy",  o_busy,  1);
      check("launch_dl_en", o_dl_en, 0);
      for (int k = 1; k <= CD + 1 + N; k++) begin
         tick();
         check("t_dl_en",    o_dl_en,        (k == CD));
         check("t_shift_en", o_shift_en,     (k > CD && k <= CD + N));
         check("t_dl",       o_dl,           (k <= CD));
         check("t_valid",    o_result_valid, (k == CD + 1 + N));
      end
      check("res_bits",  o_result_bits,  snap);
      check("res_count", o_result_count, $countones(snap));
      check("res_err",   o_result_err,   exp_err(snap));
      for (int d = 0; d < rdy_dly; d++) begin
         start = (d == 1);
         tick();
         check("hold_valid", o_result_valid, 1);
         check("hold_bits",  o_result_bits,  snap);
         check("hold_count", o_result_count, $countones(snap));
         check("hold_err",   o_result_err,   exp_err(snap));
         check("hold_dl",    o_dl,           0);
      end
      start = 1'b0;
      ready = 1'b1;
      tick();
      ready = 1'b0;
      check("acc_valid", o_result_valid, 0);
      check("acc_busy",  o_busy,         1);
      start = 1'b1;
      for (int r = 1; r <= R; r++) begin
         tick();
         check("rec_busy", o_busy, (r < R));
         check("rec_dl",   o_dl,   0);
      end
      start = 1'b0;
      tick();
      check_idle("post");
   endtask

   initial begin
      nrst  = 1'b0;
      start = 1'b0;
      ready = 1'b0;

      // Reset, with a start request that must be ignored
      tick();
      start = 1'b1;
      tick();
      tick();
      check_idle("rst");
      check("rst_bits",  o_result_bits,  0);
      check("rst_count", o_result_count, 0);
      check("rst_err",   o_result_err,   0);
      start = 1'b0;
      @(negedge clk);
      nrst = 1'b1;
      for (int i = 0; i < 3; i++) begin
         tick();
         check_idle("idle");
      end

      // Directed snapshots: thermometer, all ones, all zeros, broken code
      measure(8'b0000_0111, 0);
      measure(8'b1111_1111, 1);
      measure(8'b0000_0000, 0);
      measure(8'b0000_1101, 5);

      // Reset during the 4th shift cycle
      snapshot = 8'b0011_1111;
      start = 1'b1;
      tick();
      start = 1'b0;
      for (int k = 1; k <= CD + 4; k++) tick();
      check("pre_abort_shift", o_shift_en, 1);
      nrst = 1'b0;
      #1;
      check_idle("abort");
      tick();
      tick();
      check("abort_valid", o_result_valid, 0);
      @(negedge clk);
      nrst = 1'b1;
      tick();
      check_idle("abort_rel");
      measure(8'b0001_1111, 2);

      // Randomised snapshots, mixing legal thermometer codes with arbitrary patterns
      for (int t = 0; t < 16; t++) begin
         logic [N-1:0] s;
         if ($urandom_range(0, 1) == 0) begin
            logic [N:0] m;
            m = (N + 1)'((1 << $urandom_range(0, N)) - 1);
            s = m[N-1:0];
         end else begin
            s = N'($urandom);
         end
         measure(s, int'($urandom_range(0, 3)));
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
